// File: rtl/i2c_target_phy.sv
// I2C target bit engine: synchronizes the raw pads, detects START/STOP, matches a 7-bit address
// and moves write/read bytes with ACK handling. No general call, no clock stretching.
module i2c_target_phy #(
    parameter logic [6:0] ADDR = 7'h2A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_pull,
    output logic       start_o,
    output logic       stop_o,
    output logic       busy,
    output logic       wr_valid,
    output logic [7:0] wr_data,
    output logic       wr_first,
    output logic       rd_req,
    input  logic [7:0] rd_data
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StWrite,
        StWriteAck,
        StRead,
        StReadAck,
        StIgnore
    } state_e;

    state_e      state_q;
    logic [2:0]  scl_sync_q;
    logic [2:0]  sda_sync_q;
    logic [7:0]  shift_q;
    logic [7:0]  tx_q;
    logic [3:0]  cnt_q;
    logic        rw_q;
    logic        first_q;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall;
    logic start_det, stop_det;

    // Bit [1] is the synchronized level, bit [2] its previous value for edge detection.
    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
    assign start_det = scl_s & ~sda_sync_q[1] & sda_sync_q[2];
    assign stop_det  = scl_s & sda_sync_q[1] & ~sda_sync_q[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            shift_q    <= 8'h00;
            tx_q       <= 8'h00;
            cnt_q      <= 4'd0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            sda_pull   <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            busy       <= 1'b0;
            wr_valid   <= 1'b0;
            wr_data    <= 8'h00;
            wr_first   <= 1'b0;
            rd_req     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl_i};
            sda_sync_q <= {sda_sync_q[1:0], sda_i};
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            wr_valid   <= 1'b0;
            rd_req     <= 1'b0;

            if (start_det) begin
                state_q  <= StAddr;
                cnt_q    <= 4'd0;
                sda_pull <= 1'b0;
                busy     <= 1'b0;
                start_o  <= 1'b1;
            end else if (stop_det) begin
                state_q  <= StIdle;
                sda_pull <= 1'b0;
                busy     <= 1'b0;
                stop_o   <= 1'b1;
            end else begin
                case (state_q)
                    StAddr: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[6:0], sda_s};
                            cnt_q   <= cnt_q + 4'd1;
                        end else if (scl_fall && cnt_q == 4'd8) begin
                            if (shift_q[7:1] == ADDR) begin
                                state_q  <= StAddrAck;
                                sda_pull <= 1'b1;
                                rw_q     <= shift_q[0];
                                busy     <= 1'b1;
                                first_q  <= 1'b1;
                            end else begin
                                state_q  <= StIgnore;
                                sda_pull <= 1'b0;
                            end
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall) begin
                            if (rw_q) begin
                                state_q  <= StRead;
                                rd_req   <= 1'b1;
                                tx_q     <= rd_data;
                                sda_pull <= ~rd_data[7];
                                cnt_q    <= 4'd1;
                            end else begin
                                state_q  <= StWrite;
                                sda_pull <= 1'b0;
                                cnt_q    <= 4'd0;
                            end
                        end
                    end
                    StWrite: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[6:0], sda_s};
                            cnt_q   <= cnt_q + 4'd1;
                        end else if (scl_fall && cnt_q == 4'd8) begin
                            state_q  <= StWriteAck;
                            wr_valid <= 1'b1;
                            wr_data  <= shift_q;
                            wr_first <= first_q;
                            first_q  <= 1'b0;
                            sda_pull <= 1'b1;
                        end
                    end
                    StWriteAck: begin
                        if (scl_fall) begin
                            state_q  <= StWrite;
                            sda_pull <= 1'b0;
                            cnt_q    <= 4'd0;
                        end
                    end
                    StRead: begin
                        // cnt_q counts bits already put on the bus for this byte.
                        if (scl_fall) begin
                            if (cnt_q == 4'd8) begin
                                state_q  <= StReadAck;
                                sda_pull <= 1'b0;
                            end else begin
                                sda_pull <= ~tx_q[3'd7 - cnt_q[2:0]];
                                cnt_q    <= cnt_q + 4'd1;
                            end
                        end
                    end
                    StReadAck: begin
                        if (scl_rise && sda_s) begin
                            state_q <= StIgnore;
                            busy    <= 1'b0;
                        end else if (scl_fall) begin
                            state_q  <= StRead;
                            rd_req   <= 1'b1;
                            tx_q     <= rd_data;
                            sda_pull <= ~rd_data[7];
                            cnt_q    <= 4'd1;
                        end
                    end
                    default: begin
                        sda_pull <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_phy.sv
// Bit-level I2C master driving i2c_target_phy, with a transaction-level expectation model.
module tb_i2c_target_phy;

    localparam logic [6:0] ADDR = 7'h2A;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_pull, start_o, stop_o, busy, wr_valid, wr_first, rd_req;
    logic [7:0] wr_data;
    logic [7:0] rd_data;

    int errors = 0;
    int checks = 0;

    // Monitor-owned event log.
    int         n_start = 0;
    int         n_stop = 0;
    int         n_rd = 0;
    int         n_pull = 0;
    int         wr_n = 0;
    logic [8:0] wr_log [256];
    logic       stop_pull = 1'b0;

    // Read bytes supplied by the stimulus; the monitor advances the read pointer on rd_req.
    logic [7:0] rd_src [256];
    int         rd_wr = 0;
    int         rd_rd = 0;

    assign sda_bus = sda_m & ~sda_pull;
    assign rd_data = rd_src[rd_rd[7:0]];

    always #5 clk = ~clk;

    i2c_target_phy #(.ADDR(ADDR)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_i   (scl),
        .sda_i   (sda_bus),
        .sda_pull(sda_pull),
        .start_o (start_o),
        .stop_o  (stop_o),
        .busy    (busy),
        .wr_valid(wr_valid),
        .wr_data (wr_data),
        .wr_first(wr_first),
        .rd_req  (rd_req),
        .rd_data (rd_data)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (start_o) n_start++;
            if (stop_o) begin
                n_stop++;
                stop_pull = sda_pull;
            end
            if (sda_pull) n_pull++;
            if (wr_valid) begin
                wr_log[wr_n[7:0]] = {wr_first, wr_data};
                wr_n++;
            end
            if (rd_req) rd_rd++;
            if (rd_req) n_rd++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        wait_clk(T);
        scl = 1'b1;
        wait_clk(T);
        sda_m = 1'b0;
        wait_clk(T);
        scl = 1'b0;
        wait_clk(T);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wait_clk(T);
        scl = 1'b1;
        wait_clk(T);
        sda_m = 1'b1;
        wait_clk(T);
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sda_m = b;
        wait_clk(T);
        scl = 1'b1;
        wait_clk(T);
        r = sda_bus;
        wait_clk(T);
        scl = 1'b0;
        wait_clk(1);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(input logic ack_in, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            b[i] = r;
        end
        bit_xfer(ack_in, r);
    endtask

    task automatic push_rd(input logic [7:0] b);
        rd_src[rd_wr[7:0]] = b;
        rd_wr++;
    endtask

    initial begin
        logic       a;
        logic [7:0] b;
        logic       r;
        int         wb, sb, rb, pb, stb;

        for (int i = 0; i < 256; i++) rd_src[i] = 8'h00;

        // Reset state
        wait_clk(3);
        #2;
        check_eq("rst_sda_pull", sda_pull, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_wr_data", wr_data, 8'h00);
        check_eq("rst_wr_first", wr_first, 1'b0);
        check_eq("rst_pulses", {start_o, stop_o, wr_valid, rd_req}, 4'b0000);
        rst_n = 1'b1;
        wait_clk(5);

        // Two-byte write
        wb = wr_n; stb = n_stop;
        bus_start();
        write_byte({ADDR, 1'b0}, a);
        check_eq("w_addr_ack", a, 1'b0);
        check_eq("w_busy", busy, 1'b1);
        write_byte(8'hA5, a);
        check_eq("w_d0_ack", a, 1'b0);
        write_byte(8'h3C, a);
        check_eq("w_d1_ack", a, 1'b0);
        bus_stop();
        check_eq("w_count", wr_n - wb, 2);
        check_eq("w_byte0", wr_log[wb[7:0]], {1'b1, 8'hA5});
        check_eq("w_byte1", wr_log[8'(wb + 1)], {1'b0, 8'h3C});
        check_eq("w_stops", n_stop - stb, 1);
        check_eq("w_busy_end", busy, 1'b0);

        // Two-byte read, master ACK then NACK
        rb = n_rd;
        push_rd(8'h96);
        push_rd(8'h0F);
        wait_clk(2);
        bus_start();
        write_byte({ADDR, 1'b1}, a);
        check_eq("r_addr_ack", a, 1'b0);
        read_byte(1'b0, b);
        check_eq("r_byte0", b, 8'h96);
        check_eq("r_busy_mid", busy, 1'b1);
        read_byte(1'b1, b);
        check_eq("r_byte1", b, 8'h0F);
        check_eq("r_busy_nack", busy, 1'b0);
        bus_stop();
        check_eq("r_rdreq", n_rd - rb, 2);

        // Wrong address
        wb = wr_n; rb = n_rd; pb = n_pull;
        bus_start();
        write_byte(8'h60, a);
        check_eq("x_addr_nack", a, 1'b1);
        write_byte(8'hFF, a);
        check_eq("x_data_nack", a, 1'b1);
        bus_stop();
        check_eq("x_pull", n_pull - pb, 0);
        check_eq("x_wr", wr_n - wb, 0);
        check_eq("x_rd", n_rd - rb, 0);

        // Repeated START abandons a partial byte
        wb = wr_n; sb = n_start;
        bus_start();
        write_byte({ADDR, 1'b0}, a);
        write_byte(8'h11, a);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
        bus_start();
        write_byte({ADDR, 1'b0}, a);
        check_eq("rs_addr_ack", a, 1'b0);
        write_byte(8'h22, a);
        bus_stop();
        check_eq("rs_starts", n_start - sb, 2);
        check_eq("rs_count", wr_n - wb, 2);
        check_eq("rs_byte0", wr_log[wb[7:0]], {1'b1, 8'h11});
        check_eq("rs_byte1", wr_log[8'(wb + 1)], {1'b1, 8'h22});

        // Reset while driving the write ACK
        bus_start();
        write_byte({ADDR, 1'b0}, a);
        for (int i = 7; i >= 0; i--) bit_xfer(1'(8'hA5 >> i), r);
        wait_clk(4);
        check_eq("ra_pull_before", sda_pull, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("ra_pull_async", sda_pull, 1'b0);
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        wb = wr_n;
        bit_xfer(1'b1, r);
        check_eq("ra_ack_slot", r, 1'b1);
        write_byte(8'h77, a);
        check_eq("ra_ignored_ack", a, 1'b1);
        check_eq("ra_no_wr", wr_n - wb, 0);
        bus_stop();
        bus_start();
        write_byte({ADDR, 1'b0}, a);
        write_byte(8'h3C, a);
        bus_stop();
        check_eq("ra_fresh_count", wr_n - wb, 1);
        check_eq("ra_fresh_byte", wr_log[wb[7:0]], {1'b1, 8'h3C});

        // STOP while the target is driving read bit 3
        rb = n_rd; stb = n_stop;
        push_rd(8'hC8);
        wait_clk(2);
        bus_start();
        write_byte({ADDR, 1'b1}, a);
        for (int i = 7; i >= 4; i--) begin
            bit_xfer(1'b1, r);
            b[i] = r;
        end
        check_eq("sr_hi_nibble", b[7:4], 4'hC);
        bus_stop();
        check_eq("sr_stop", n_stop - stb, 1);
        check_eq("sr_stop_pull", stop_pull, 1'b0);
        check_eq("sr_busy", busy, 1'b0);
        pb = n_pull;
        for (int i = 0; i < 9; i++) bit_xfer(1'b1, r);
        check_eq("sr_rdreq", n_rd - rb, 1);
        check_eq("sr_no_pull", n_pull - pb, 0);
        bus_stop();

        // Randomized transactions against the transaction-level model
        for (int t = 0; t < 8; t++) begin
            logic [6:0] addr7;
            logic       rw, match;
            int         n;
            logic [7:0] exp_b [4];

            addr7 = ($urandom_range(0, 1) == 0) ? ADDR : 7'($urandom_range(1, 127));
            if (addr7 == ADDR && $urandom_range(0, 3) == 0) addr7 = ADDR ^ 7'h01;
            rw    = 1'($urandom_range(0, 1));
            n     = $urandom_range(1, 3);
            match = (addr7 == ADDR);
            for (int k = 0; k < n; k++) exp_b[k] = 8'($urandom);
            if (match && rw) for (int k = 0; k < n; k++) push_rd(exp_b[k]);
            wb = wr_n; rb = n_rd; stb = n_stop;
            wait_clk(2);
            bus_start();
            write_byte({addr7, rw}, a);
            check_eq($sformatf("rnd%0d_addr_ack", t), a, !match);
            for (int k = 0; k < n; k++) begin
                if (!rw) begin
                    write_byte(exp_b[k], a);
                    check_eq($sformatf("rnd%0d_wack%0d", t, k), a, !match);
                end else begin
                    read_byte(k == n - 1, b);
                    check_eq($sformatf("rnd%0d_rd%0d", t, k), b, match ? exp_b[k] : 8'hFF);
                end
            end
            bus_stop();
            check_eq($sformatf("rnd%0d_wr_count", t), wr_n - wb, (match && !rw) ? n : 0);
            if (match && !rw)
                for (int k = 0; k < n; k++)
                    check_eq($sformatf("rnd%0d_wr%0d", t, k), wr_log[8'(wb + k)],
                             {k == 0, exp_b[k]});
            check_eq($sformatf("rnd%0d_rdreq", t), n_rd - rb, (match && rw) ? n : 0);
            check_eq($sformatf("rnd%0d_stop", t), n_stop - stb, 1);
            check_eq($sformatf("rnd%0d_busy", t), busy, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
